// File: rtl/vdp18_ctrl_gen.sv
// vdp18_ctrl_gen: VRAM slot decode, display/sprite window flags and frame interrupt.
// Optional macro VDP_LINE_IRQ_EN adds a programmable line interrupt (irq_line_i, line_irq_o).
module vdp18_ctrl_gen #(
  parameter int unsigned SPR_SLOTS     = 4,
  parameter int unsigned LINES_A       = 192,
  parameter int unsigned LINES_B       = 212,
  parameter int unsigned SPR_REARM_PIX = 248
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clk_en_5m37_i,
  input  logic [1:0]        opmode_i,
  input  logic signed [8:0] num_pix_i,
  input  logic signed [8:0] num_line_i,
  input  logic              vert_inc_i,
  input  logic              reg_blank_i,
  input  logic              reg_size1_i,
  input  logic              line_mode_i,
  input  logic              stop_sprite_i,
  input  logic              irq_en_i,
  input  logic              irq_ack_i,
`ifdef VDP_LINE_IRQ_EN
  input  logic signed [8:0] irq_line_i,
  output logic              line_irq_o,
`endif
  output logic              clk_en_acc_o,
  output logic [3:0]        access_type_o,
  output logic              vert_active_o,
  output logic              hor_active_o,
  output logic              sprite_line_act_o,
  output logic              irq_o
);

  if (SPR_SLOTS == 0 || SPR_SLOTS > 5) begin : g_bad_spr_slots
    $error("vdp18_ctrl_gen: SPR_SLOTS must be in 1..5");
  end

  localparam int NSLOT    = int'(SPR_SLOTS);
  localparam int GRP_BASE = -86;

  localparam logic [1:0] MODE_MULTIC = 2'd2;
  localparam logic [1:0] MODE_TEXTM  = 2'd3;

  localparam logic [3:0] AT_CPU  = 4'd0;
  localparam logic [3:0] AT_PNT  = 4'd1;
  localparam logic [3:0] AT_PCT  = 4'd2;
  localparam logic [3:0] AT_PGT  = 4'd3;
  localparam logic [3:0] AT_SATY = 4'd4;
  localparam logic [3:0] AT_SATX = 4'd5;
  localparam logic [3:0] AT_SATN = 4'd6;
  localparam logic [3:0] AT_SATC = 4'd7;
  localparam logic [3:0] AT_SPTH = 4'd8;
  localparam logic [3:0] AT_SPTL = 4'd9;
  localparam logic [3:0] AT_STST = 4'd10;

  localparam logic signed [8:0] LINE_M1    = -9'sd1;
  localparam logic signed [8:0] LINE_M2    = -9'sd2;
  localparam logic signed [8:0] LAST_A     = 9'(LINES_A - 1);
  localparam logic signed [8:0] LAST_B     = 9'(LINES_B - 1);
  localparam logic signed [8:0] PIX_M1     = -9'sd1;
  localparam logic signed [8:0] PIX_REARM  = 9'(SPR_REARM_PIX);
  localparam logic signed [8:0] PIX_GFX_LO = -9'sd8;
  localparam logic signed [8:0] PIX_ZERO   = 9'sd0;
  localparam logic signed [8:0] PIX_247    = 9'sd247;
  localparam logic signed [8:0] PIX_SATY0  = 9'sd250;
  localparam logic signed [8:0] PIX_SATN0  = 9'sd252;
  localparam logic signed [8:0] PIX_SATX0  = 9'sd254;

  logic              lines_sel_q;
  logic              vert_active_q;
  logic              spr_active_q;
  logic              spr_line_act_q;
  logic              hor_active_q;
  logic              frame_pend_q;
  logic signed [8:0] last_line;
  logic signed [8:0] hor_end;
  logic signed [9:0] q_pix;
  logic [2:0]        q_mod;
  logic              text_win;
  logic              gfx_win;
  logic              stst_win;
  logic [8:0]        rel;

  assign last_line = lines_sel_q ? LAST_B : LAST_A;
  assign hor_end   = (opmode_i == MODE_TEXTM) ? 9'sd239 : 9'sd255;

  // Window flags and frame pending; the last matching rule in each group wins
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lines_sel_q    <= 1'b0;
      vert_active_q  <= 1'b0;
      spr_active_q   <= 1'b0;
      spr_line_act_q <= 1'b0;
      hor_active_q   <= 1'b0;
      frame_pend_q   <= 1'b0;
    end else if (clk_en_5m37_i) begin
      if (vert_inc_i && num_line_i == LINE_M2) lines_sel_q <= line_mode_i;
      if (vert_inc_i) begin
        if (reg_blank_i) begin
          vert_active_q <= 1'b0;
          spr_active_q  <= 1'b0;
        end
        if (num_line_i == LINE_M1) vert_active_q <= 1'b1;
        if (num_line_i == LINE_M2) spr_active_q  <= 1'b1;
        if (num_line_i == last_line) begin
          vert_active_q <= 1'b0;
          spr_active_q  <= 1'b0;
        end
      end
      if (spr_active_q && (vert_inc_i || num_pix_i == PIX_REARM)) spr_line_act_q <= 1'b1;
      if (stop_sprite_i) spr_line_act_q <= 1'b0;
      if (num_pix_i == PIX_M1 && !reg_blank_i) hor_active_q <= 1'b1;
      if (num_pix_i == hor_end) hor_active_q <= 1'b0;
      if (irq_ack_i) frame_pend_q <= 1'b0;
      if (vert_inc_i && num_line_i == last_line) frame_pend_q <= 1'b1;
    end
  end

  // Text slots repeat every 6 pixels across a 240-pixel window starting at pix -6
  assign q_pix    = 10'(num_pix_i) + 10'sd6;
  assign q_mod    = 3'(q_pix[7:0] % 8'd6);
  assign text_win = (q_pix >= 10'sd0) && (q_pix < 10'sd240);
  // pix+8 keeps the low three bits, so the graphics phase is read straight off num_pix_i
  assign gfx_win  = (num_pix_i >= PIX_GFX_LO) && (num_pix_i <= PIX_247);
  assign stst_win = (num_pix_i >= PIX_ZERO) && (num_pix_i <= PIX_247);

  always_comb begin
    access_type_o = AT_CPU;
    rel           = '0;
    if (opmode_i == MODE_TEXTM) begin
      if (vert_active_q && text_win) begin
        case (q_mod)
          3'd0, 3'd1: access_type_o = AT_PNT;
          3'd4, 3'd5: access_type_o = AT_PGT;
          default:    access_type_o = AT_CPU;
        endcase
      end
    end else begin
      if (vert_active_q && gfx_win) begin
        case (num_pix_i[2:1])
          2'b01:   access_type_o = AT_PNT;
          2'b10:   access_type_o = (opmode_i == MODE_MULTIC) ? AT_CPU : AT_PCT;
          2'b11:   access_type_o = AT_PGT;
          default: access_type_o = AT_CPU;
        endcase
      end
      if (spr_line_act_q) begin
        if (stst_win && num_pix_i[2:1] == 2'b00 && num_pix_i[4:3] != 2'b00)
          access_type_o = AT_STST;
        case (num_pix_i)
          PIX_SATY0: access_type_o = AT_SATY;
          PIX_SATN0: access_type_o = AT_SATN;
          PIX_SATX0: access_type_o = AT_SATX;
          default: ;
        endcase
        // The last group has no attribute preload for a following sprite
        for (int k = 0; k < NSLOT; k++) begin
          rel = 9'(num_pix_i - 9'(GRP_BASE + 16 * k));
          case (rel)
            9'd0:  access_type_o = AT_SATC;
            9'd2:  access_type_o = AT_SPTH;
            9'd4:  if (reg_size1_i) access_type_o = AT_SPTL;
            9'd8:  if (k < NSLOT - 1) access_type_o = AT_SATY;
            9'd10: if (k < NSLOT - 1) access_type_o = AT_SATX;
            9'd12: if (k < NSLOT - 1) access_type_o = AT_SATN;
            default: ;
          endcase
        end
      end
    end
  end

  assign clk_en_acc_o      = clk_en_5m37_i & num_pix_i[0];
  assign vert_active_o     = vert_active_q;
  assign hor_active_o      = hor_active_q;
  assign sprite_line_act_o = spr_line_act_q;

`ifdef VDP_LINE_IRQ_EN
  logic line_pend_q;

  // Programmable line interrupt; a set coinciding with an ack wins
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      line_pend_q <= 1'b0;
    end else if (clk_en_5m37_i) begin
      if (irq_ack_i) line_pend_q <= 1'b0;
      if (vert_inc_i && num_line_i == irq_line_i && !reg_blank_i) line_pend_q <= 1'b1;
    end
  end

  assign line_irq_o = line_pend_q;
  assign irq_o      = (frame_pend_q & irq_en_i) | line_pend_q;
`else
  assign irq_o      = frame_pend_q & irq_en_i;
`endif

endmodule

// File: tb/tb_vdp18_ctrl_gen.sv
// Bench for vdp18_ctrl_gen: directed vectors, spec-level model checked every cycle
// plus literal expectations. Honours VDP_LINE_IRQ_EN when defined.
module tb_vdp18_ctrl_gen;

  localparam int NSPR    = 5;
  localparam int LINES_A = 192;
  localparam int LINES_B = 212;
  localparam int REARM   = 248;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              clk_en_5m37_i;
  logic [1:0]        opmode_i;
  logic signed [8:0] num_pix_i;
  logic signed [8:0] num_line_i;
  logic              vert_inc_i;
  logic              reg_blank_i;
  logic              reg_size1_i;
  logic              line_mode_i;
  logic              stop_sprite_i;
  logic              irq_en_i;
  logic              irq_ack_i;
  logic              clk_en_acc_o;
  logic [3:0]        access_type_o;
  logic              vert_active_o;
  logic              hor_active_o;
  logic              sprite_line_act_o;
  logic              irq_o;
`ifdef VDP_LINE_IRQ_EN
  logic signed [8:0] irq_line_i;
  logic              line_irq_o;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Model state
  bit m_nsel, m_vact, m_sact, m_slact, m_hact, m_fpend, m_lpend;

  vdp18_ctrl_gen #(.SPR_SLOTS(NSPR)) dut (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
    .clk_en_5m37_i     (clk_en_5m37_i),
    .opmode_i          (opmode_i),
    .num_pix_i         (num_pix_i),
    .num_line_i        (num_line_i),
    .vert_inc_i        (vert_inc_i),
    .reg_blank_i       (reg_blank_i),
    .reg_size1_i       (reg_size1_i),
    .line_mode_i       (line_mode_i),
    .stop_sprite_i     (stop_sprite_i),
    .irq_en_i          (irq_en_i),
    .irq_ack_i         (irq_ack_i),
`ifdef VDP_LINE_IRQ_EN
    .irq_line_i        (irq_line_i),
    .line_irq_o        (line_irq_o),
`endif
    .clk_en_acc_o      (clk_en_acc_o),
    .access_type_o     (access_type_o),
    .vert_active_o     (vert_active_o),
    .hor_active_o      (hor_active_o),
    .sprite_line_act_o (sprite_line_act_o),
    .irq_o             (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Slot type from pixel position, mode and the current window flags
  function automatic int exp_access(input int mode, input int pix, input bit vact,
                                    input bit slact, input bit size1);
    int r = 0;
    if (mode == 3) begin
      int q = pix + 6;
      if (vact && q >= 0 && q < 240) begin
        if (q % 6 < 2) r = 1;
        else if (q % 6 >= 4) r = 3;
      end
    end else begin
      int p = pix + 8;
      if (vact && p >= 0 && p < 256) begin
        int ph = (p % 8) / 2;
        if (ph == 1) r = 1;
        else if (ph == 2) r = (mode == 2) ? 0 : 2;
        else if (ph == 3) r = 3;
      end
      if (slact) begin
        if (pix >= 0 && pix <= 247 && (pix % 8) < 2 && (pix % 32) >= 8) r = 10;
        if (pix == 250) r = 4;
        if (pix == 252) r = 6;
        if (pix == 254) r = 5;
        for (int k = 0; k < NSPR; k++) begin
          int d = pix - (-86 + 16 * k);
          if (d == 0) r = 7;
          if (d == 2) r = 8;
          if (d == 4 && size1) r = 9;
          if (k < NSPR - 1) begin
            if (d == 8)  r = 4;
            if (d == 10) r = 5;
            if (d == 12) r = 6;
          end
        end
      end
    end
    return r;
  endfunction

  // Model of the registered flags
  always @(posedge clk_i or negedge reset_n_i) begin
    int pix, line, last, iline;
    bit vact_n, sact_n, slact_n, hact_n, fpend_n, nsel_n, lpend_n;
    if (!reset_n_i) begin
      m_nsel = 0; m_vact = 0; m_sact = 0; m_slact = 0;
      m_hact = 0; m_fpend = 0; m_lpend = 0;
    end else if (clk_en_5m37_i) begin
      pix  = int'(num_pix_i);
      line = int'(num_line_i);
      last = (m_nsel ? LINES_B : LINES_A) - 1;
      vact_n = !vert_inc_i ? m_vact : (line == last) ? 1'b0 : (line == -1) ? 1'b1
             : reg_blank_i ? 1'b0 : m_vact;
      sact_n = !vert_inc_i ? m_sact : (line == last) ? 1'b0 : (line == -2) ? 1'b1
             : reg_blank_i ? 1'b0 : m_sact;
      slact_n = stop_sprite_i ? 1'b0
              : (m_sact && (vert_inc_i || pix == REARM)) ? 1'b1 : m_slact;
      hact_n = (pix == ((opmode_i == 2'd3) ? 239 : 255)) ? 1'b0
             : (pix == -1 && !reg_blank_i) ? 1'b1 : m_hact;
      fpend_n = (vert_inc_i && line == last) ? 1'b1 : irq_ack_i ? 1'b0 : m_fpend;
      nsel_n  = (vert_inc_i && line == -2) ? line_mode_i : m_nsel;
`ifdef VDP_LINE_IRQ_EN
      iline = int'(irq_line_i);
`else
      iline = 1000;
`endif
      lpend_n = (vert_inc_i && line == iline && !reg_blank_i) ? 1'b1
              : irq_ack_i ? 1'b0 : m_lpend;
      m_vact = vact_n; m_sact = sact_n; m_slact = slact_n; m_hact = hact_n;
      m_fpend = fpend_n; m_nsel = nsel_n; m_lpend = lpend_n;
    end
  end

  // Per-cycle comparison against the model
  always @(posedge clk_i) begin
    #1;
    if (chk_on) begin
      chk("model_access", int'(access_type_o),
          exp_access(int'(opmode_i), int'(num_pix_i), m_vact, m_slact, reg_size1_i));
      chk("model_vact", int'(vert_active_o), int'(m_vact));
      chk("model_hact", int'(hor_active_o), int'(m_hact));
      chk("model_slact", int'(sprite_line_act_o), int'(m_slact));
      chk("model_acc_en", int'(clk_en_acc_o), int'(clk_en_5m37_i & num_pix_i[0]));
`ifdef VDP_LINE_IRQ_EN
      chk("model_irq", int'(irq_o), int'((m_fpend & irq_en_i) | m_lpend));
      chk("model_line_irq", int'(line_irq_o), int'(m_lpend));
`else
      chk("model_irq", int'(irq_o), int'(m_fpend & irq_en_i));
`endif
    end
  end

  task automatic cyc(input int pix, input int line, input bit vinc);
    @(negedge clk_i);
    num_pix_i  = 9'(pix);
    num_line_i = 9'(line);
    vert_inc_i = vinc;
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    reset_n_i = 0; clk_en_5m37_i = 1; opmode_i = 2'd1; num_pix_i = '0; num_line_i = '0;
    vert_inc_i = 0; reg_blank_i = 0; reg_size1_i = 0; line_mode_i = 0;
    stop_sprite_i = 0; irq_en_i = 1; irq_ack_i = 0;
`ifdef VDP_LINE_IRQ_EN
    irq_line_i = 9'sd50;
`endif
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_vact", int'(vert_active_o), 0);
    chk("rst_slact", int'(sprite_line_act_o), 0);
    chk("rst_irq", int'(irq_o), 0);
    chk("rst_access", int'(access_type_o), 0);
    @(negedge clk_i);
    reset_n_i = 1;
    chk_on = 1;

    // Frame start, GRAPH2
    cyc(-6, -2, 1); chk("pre_frame_access", int'(access_type_o), 0);
    cyc(-1, -1, 1); chk("vact_set", int'(vert_active_o), 1);
    chk("slact_set", int'(sprite_line_act_o), 1);
    chk("hact_set", int'(hor_active_o), 1);
    cyc(-6, 0, 0); chk("g2_pnt", int'(access_type_o), 1);
    cyc(-4, 0, 0); chk("g2_pct", int'(access_type_o), 2);
    cyc(-2, 0, 0); chk("g2_pgt", int'(access_type_o), 3);
    opmode_i = 2'd2;
    cyc(-6, 0, 0); chk("mc_pnt", int'(access_type_o), 1);
    cyc(-4, 0, 0); chk("mc_cpu", int'(access_type_o), 0);
    cyc(-2, 0, 0); chk("mc_pgt", int'(access_type_o), 3);
    opmode_i = 2'd1;

    // Sprite groups with five slots
    cyc(-22, 0, 0); chk("g4_satc", int'(access_type_o), 7);
    cyc(-20, 0, 0); chk("g4_spth", int'(access_type_o), 8);
    cyc(-18, 0, 0); chk("g4_no_sptl", int'(access_type_o), 0);
    cyc(-14, 0, 0); chk("g4_no_saty", int'(access_type_o), 0);
    cyc(-30, 0, 0); chk("g3_saty", int'(access_type_o), 4);
    reg_size1_i = 1;
    cyc(-18, 0, 0); chk("g4_sptl", int'(access_type_o), 9);
    reg_size1_i = 0;
    cyc(16, 0, 0); chk("stst", int'(access_type_o), 10);

    // Stop and re-arm
    stop_sprite_i = 1;
    cyc(100, 0, 0); chk("stop_clears", int'(sprite_line_act_o), 0);
    stop_sprite_i = 0;
    cyc(16, 0, 0); chk("no_stst", int'(access_type_o), 0);
    cyc(128, 0, 0); chk("pix128_cpu", int'(access_type_o), 0);
    cyc(248, 0, 0); chk("rearm", int'(sprite_line_act_o), 1);
    cyc(250, 0, 0); chk("pre_saty", int'(access_type_o), 4);
    clk_en_5m37_i = 0; stop_sprite_i = 1;
    cyc(11, 0, 0); chk("clk_en_gate", int'(sprite_line_act_o), 1);
    clk_en_5m37_i = 1; stop_sprite_i = 0;
    cyc(255, 0, 0); chk("hact_clr255", int'(hor_active_o), 0);

    // Text mode
    opmode_i = 2'd3;
    cyc(-6, 0, 0);  chk("tx_pnt", int'(access_type_o), 1);
    cyc(-4, 0, 0);  chk("tx_cpu", int'(access_type_o), 0);
    cyc(-2, 0, 0);  chk("tx_pgt", int'(access_type_o), 3);
    cyc(233, 0, 0); chk("tx_last_pgt", int'(access_type_o), 3);
    cyc(234, 0, 0); chk("tx_outside", int'(access_type_o), 0);
    cyc(-1, 0, 0);
    cyc(239, 0, 0); chk("hact_clr239", int'(hor_active_o), 0);
    opmode_i = 2'd1;

    // 212-line frame, mid-frame line_mode change ignored
    line_mode_i = 1;
    cyc(0, -2, 1);
    line_mode_i = 0;
    cyc(0, -1, 1);
    cyc(0, 191, 1); chk("n212_vact191", int'(vert_active_o), 1);
    chk("n212_irq191", int'(irq_o), 0);
    cyc(0, 211, 1); chk("n212_vact211", int'(vert_active_o), 0);
    chk("irq_set", int'(irq_o), 1);
    irq_en_i = 0;
    cyc(0, 0, 0); chk("irq_masked", int'(irq_o), 0);
    irq_en_i = 1;
    irq_ack_i = 1;
    cyc(0, 211, 1); chk("irq_set_wins", int'(irq_o), 1);
    cyc(0, 0, 0); chk("irq_acked", int'(irq_o), 0);
    irq_ack_i = 0;

    // Back to 192 lines at the next frame, then blanking
    cyc(0, -2, 1);
    cyc(0, -1, 1);
    cyc(0, 191, 1); chk("n192_vact191", int'(vert_active_o), 0);
    cyc(0, -1, 1);
    reg_blank_i = 1;
    cyc(0, 5, 1); chk("blank_vact", int'(vert_active_o), 0);
    cyc(-1, 5, 0); chk("blank_hact", int'(hor_active_o), 0);
    reg_blank_i = 0;

`ifdef VDP_LINE_IRQ_EN
    irq_ack_i = 1;
    cyc(0, 50, 1); chk("line_irq_collide", int'(line_irq_o), 1);
    cyc(0, 51, 0); chk("line_irq_ack", int'(line_irq_o), 0);
    irq_ack_i = 0;
`endif

    // Asynchronous reset with display active and irq pending
    cyc(0, 191, 1);
    cyc(0, -2, 1);
    cyc(-1, -1, 1);
    cyc(-6, 0, 0); chk("pre_rst_access", int'(access_type_o), 1);
    chk("pre_rst_irq", int'(irq_o), 1);
    #1 reset_n_i = 0;
    #1;
    chk("arst_vact", int'(vert_active_o), 0);
    chk("arst_hact", int'(hor_active_o), 0);
    chk("arst_slact", int'(sprite_line_act_o), 0);
    chk("arst_irq", int'(irq_o), 0);
    chk("arst_access", int'(access_type_o), 0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1;
    cyc(-6, 0, 0); chk("post_rst_access", int'(access_type_o), 0);
    cyc(0, -1, 1);
    cyc(-6, 0, 0); chk("post_rst_pnt", int'(access_type_o), 1);

    chk_on = 0;
    @(posedge clk_i);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
